chr_fetch_port: RTL

//  Owns the CHR SRAM once the CHR loader reports done; passes loader SRAM signals through until then.

---
 rtl/chr_fetch_port_pkg.sv | 21 ++
 rtl/chr_fetch_port_bank_regs.sv | 31 +++
 rtl/chr_fetch_port.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/chr_fetch_port_pkg.sv
// Shared definitions for the CHR fetch port: FSM states, sizes and SRAM word packing.
package chr_fetch_port_pkg;

  localparam int CHR_BANK_CNT = 8;
  localparam int PPU_AW       = 13;
  localparam int SRAM_AW      = 20;

  typedef enum logic [1:0] {
    S_WAIT_LD = 2'd0,
    S_IDLE    = 2'd1,
    S_ADDR    = 2'd2,
    S_DONE    = 2'd3
  } chr_state_e;

  // Byte-granular CHR address to SRAM word address. A[3] selects the plane
  // byte, so it is dropped and the word index is {A[19:4], A[2:0]}.
  function automatic logic [SRAM_AW-1:0] chr_word_addr(input logic [SRAM_AW-1:0] a);
    return {1'b0, a[19:4], a[2:0]};
  endfunction

endpackage

// File: rtl/chr_fetch_port_bank_regs.sv
// Eight CHR bank registers: one write port, combinational read by PPU 1 KB window index.
module chr_fetch_port_bank_regs
  import chr_fetch_port_pkg::*;
#(
  parameter int BANK_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [2:0]        i_wr_idx,
  input  logic [BANK_W-1:0] i_wr_val,
  input  logic [2:0]        i_rd_idx,
  output logic [BANK_W-1:0] o_rd_val
);

  logic [BANK_W-1:0] bank_q [CHR_BANK_CNT];

  // Identity mapping out of reset; writes land in any state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < CHR_BANK_CNT; n++) begin
        bank_q[n] <= BANK_W'(n);
      end
    end else if (i_we) begin
      bank_q[i_wr_idx] <= i_wr_val;
    end
  end

  assign o_rd_val = bank_q[i_rd_idx];

endmodule

// File: rtl/chr_fetch_port.sv
// CHR SRAM fetch port: loader pass-through until done, then banked PPU pattern reads.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  S_WAIT_LD | loader owns the SRAM, o_sram_* mirror i_ld_*
//  S_IDLE    | ready for a PPU read, SRAM address parked at 0
//  S_ADDR    | word address held on SRAM for RD_WAIT+1 cycles
//  S_DONE    | captured word/byte presented with o_rd_valid for one cycle
module chr_fetch_port
  import chr_fetch_port_pkg::*;
#(
  parameter int BANK_W  = 10,
  parameter int RD_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_done,
  input  logic [19:0]       i_ld_addr,
  input  logic [15:0]       i_ld_wdata,
  input  logic              i_ld_oe_n,
  input  logic              i_ld_we_n,
  input  logic              i_ld_ub_n,
  input  logic              i_ld_lb_n,
  input  logic              i_bank_we,
  input  logic [2:0]        i_bank_idx,
  input  logic [BANK_W-1:0] i_bank_val,
  input  logic              i_rd_req,
  input  logic [12:0]       i_rd_addr,
  input  logic [15:0]       i_sram_rdata,
  output logic              o_rd_ready,
  output logic              o_rd_valid,
  output logic [15:0]       o_rd_word,
  output logic [7:0]        o_rd_byte,
  output logic [19:0]       o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n
);

  chr_state_e        state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic              done_q;
  logic [19:0]       addr_q;
  logic              hi_q;
  logic [15:0]       word_q;
  logic [7:0]        byte_q;
  logic [BANK_W-1:0] bank_sel;
  logic [19:0]       a_phys;
  logic              accept;
  logic              capture;

  chr_fetch_port_bank_regs #(.BANK_W(BANK_W)) u_bank_regs (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (i_bank_we),
    .i_wr_idx (i_bank_idx),
    .i_wr_val (i_bank_val),
    .i_rd_idx (i_rd_addr[12:10]),
    .o_rd_val (bank_sel)
  );

  assign a_phys  = 20'({bank_sel, i_rd_addr[9:0]});
  assign accept  = (state_q == S_IDLE) && i_rd_req;
  assign capture = (state_q == S_ADDR) && (wait_q == 2'd0);

  // Loader done is sticky: a later fall of i_ld_done does not hand the SRAM back.
  always_ff @(posedge i_clk) begin
    if (i_rst) done_q <= 1'b0;
    else if (i_ld_done) done_q <= 1'b1;
  end

  // State and wait-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_WAIT_LD;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; the wait counter runs down to zero while in S_ADDR.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_WAIT_LD: if (done_q) state_d = S_IDLE;
      S_IDLE: begin
        if (i_rd_req) begin
          state_d = S_ADDR;
          wait_d  = 2'(RD_WAIT);
        end
      end
      S_ADDR: begin
        if (wait_q == 2'd0) state_d = S_DONE;
        else wait_d = wait_q - 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_WAIT_LD;
    endcase
  end

  // Latch the word address at acceptance (old bank value wins a same-cycle write),
  // and capture SRAM data on the last address cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= 20'd0;
      hi_q   <= 1'b0;
      word_q <= 16'd0;
      byte_q <= 8'd0;
    end else begin
      if (accept) begin
        addr_q <= chr_word_addr(a_phys);
        hi_q   <= a_phys[3];
      end
      if (capture) begin
        word_q <= i_sram_rdata;
        byte_q <= hi_q ? i_sram_rdata[15:8] : i_sram_rdata[7:0];
      end
    end
  end

  // SRAM ownership mux: loader until done, then read-only word access.
  always_comb begin
    o_sram_addr  = 20'd0;
    o_sram_wdata = 16'd0;
    o_sram_oe_n  = 1'b0;
    o_sram_we_n  = 1'b1;
    o_sram_ub_n  = 1'b0;
    o_sram_lb_n  = 1'b0;
    if (state_q == S_WAIT_LD) begin
      o_sram_addr  = i_ld_addr;
      o_sram_wdata = i_ld_wdata;
      o_sram_oe_n  = i_ld_oe_n;
      o_sram_we_n  = i_ld_we_n;
      o_sram_ub_n  = i_ld_ub_n;
      o_sram_lb_n  = i_ld_lb_n;
    end else if (state_q != S_IDLE) begin
      o_sram_addr = addr_q;
    end
  end

  assign o_rd_ready = (state_q == S_IDLE);
  assign o_rd_valid = (state_q == S_DONE);
  assign o_rd_word  = word_q;
  assign o_rd_byte  = byte_q;

endmodule
